// File: rtl/acc_row_packer.sv
// Packs 64-bit VME read beats into 16 x 32-bit accumulator rows and writes each completed row.
// Optional build macro ACC_PACK_TAG_CHECK_EN: drop and flag beats whose tag differs from the started tag.
module acc_row_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [10:0] io_row_base,
  input  logic [11:0] io_row_cnt,
  input  logic [20:0] io_tag,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_tag_err,
  output logic        io_vme_rd_data_ready,
  input  logic        io_vme_rd_data_valid,
  input  logic [63:0] io_vme_rd_data_bits_data,
  input  logic [20:0] io_vme_rd_data_bits_tag,
  output logic        io_tensor_wr_0_valid,
  output logic [10:0] io_tensor_wr_0_bits_idx,
  output logic [31:0] io_tensor_wr_0_bits_data_0_0,
  output logic [31:0] io_tensor_wr_0_bits_data_0_1,
  output logic [31:0] io_tensor_wr_0_bits_data_0_2,
  output logic [31:0] io_tensor_wr_0_bits_data_0_3,
  output logic [31:0] io_tensor_wr_0_bits_data_0_4,
  output logic [31:0] io_tensor_wr_0_bits_data_0_5,
  output logic [31:0] io_tensor_wr_0_bits_data_0_6,
  output logic [31:0] io_tensor_wr_0_bits_data_0_7,
  output logic [31:0] io_tensor_wr_0_bits_data_0_8,
  output logic [31:0] io_tensor_wr_0_bits_data_0_9,
  output logic [31:0] io_tensor_wr_0_bits_data_0_10,
  output logic [31:0] io_tensor_wr_0_bits_data_0_11,
  output logic [31:0] io_tensor_wr_0_bits_data_0_12,
  output logic [31:0] io_tensor_wr_0_bits_data_0_13,
  output logic [31:0] io_tensor_wr_0_bits_data_0_14,
  output logic [31:0] io_tensor_wr_0_bits_data_0_15
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;

  logic [0:0]  r_state;
  logic [10:0] r_base;
  logic [11:0] r_cnt;
  logic [2:0]  r_beat;
  logic [11:0] r_row;
  logic [31:0] r_buf [0:15];
  logic [31:0] r_out [0:15];
  logic        r_wr_valid;
  logic [10:0] r_idx;
  logic        r_done;

  logic w_accept;
  logic w_tag_ok;
  logic w_last_row;

  assign w_accept   = io_vme_rd_data_valid & (r_state == ST_PACK);
  assign w_last_row = (r_row == (r_cnt - 12'd1));

`ifdef ACC_PACK_TAG_CHECK_EN
  logic [20:0] r_tag;
  logic        r_tag_err;

  assign w_tag_ok   = (io_vme_rd_data_bits_tag == r_tag);
  assign io_tag_err = r_tag_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag     <= 21'd0;
      r_tag_err <= 1'b0;
    end else if (r_state == ST_IDLE && io_start) begin
      r_tag     <= io_tag;
      r_tag_err <= 1'b0;
    end else if (w_accept && !w_tag_ok) begin
      r_tag_err <= 1'b1;
    end
  end
`else
  logic w_unused_tags;

  assign w_unused_tags = ^{io_tag, io_vme_rd_data_bits_tag};
  assign w_tag_ok      = 1'b1;
  assign io_tag_err    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_base     <= 11'd0;
      r_cnt      <= 12'd0;
      r_beat     <= 3'd0;
      r_row      <= 12'd0;
      r_wr_valid <= 1'b0;
      r_idx      <= 11'd0;
      r_done     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 32'd0;
        r_out[i] <= 32'd0;
      end
    end else begin
      r_wr_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            if (io_row_cnt == 12'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_PACK;
              r_base  <= io_row_base;
              r_cnt   <= io_row_cnt;
              r_beat  <= 3'd0;
              r_row   <= 12'd0;
            end
          end
        end
        default: begin
          if (w_accept && w_tag_ok) begin
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) begin
              // Row leaves the staging buffer whole; output slots never see a partial row.
              for (int i = 0; i < 14; i++) begin
                r_out[i] <= r_buf[i];
              end
              r_out[14]  <= io_vme_rd_data_bits_data[31:0];
              r_out[15]  <= io_vme_rd_data_bits_data[63:32];
              r_wr_valid <= 1'b1;
              r_idx      <= r_base + r_row[10:0];
              r_row      <= r_row + 12'd1;
              if (w_last_row) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_buf[{r_beat, 1'b0}] <= io_vme_rd_data_bits_data[31:0];
              r_buf[{r_beat, 1'b1}] <= io_vme_rd_data_bits_data[63:32];
            end
          end
        end
      endcase
    end
  end

  assign io_busy                 = (r_state == ST_PACK);
  assign io_vme_rd_data_ready    = (r_state == ST_PACK);
  assign io_done                 = r_done;
  assign io_tensor_wr_0_valid    = r_wr_valid;
  assign io_tensor_wr_0_bits_idx = r_idx;

  assign io_tensor_wr_0_bits_data_0_0  = r_out[0];
  assign io_tensor_wr_0_bits_data_0_1  = r_out[1];
  assign io_tensor_wr_0_bits_data_0_2  = r_out[2];
  assign io_tensor_wr_0_bits_data_0_3  = r_out[3];
  assign io_tensor_wr_0_bits_data_0_4  = r_out[4];
  assign io_tensor_wr_0_bits_data_0_5  = r_out[5];
  assign io_tensor_wr_0_bits_data_0_6  = r_out[6];
  assign io_tensor_wr_0_bits_data_0_7  = r_out[7];
  assign io_tensor_wr_0_bits_data_0_8  = r_out[8];
  assign io_tensor_wr_0_bits_data_0_9  = r_out[9];
  assign io_tensor_wr_0_bits_data_0_10 = r_out[10];
  assign io_tensor_wr_0_bits_data_0_11 = r_out[11];
  assign io_tensor_wr_0_bits_data_0_12 = r_out[12];
  assign io_tensor_wr_0_bits_data_0_13 = r_out[13];
  assign io_tensor_wr_0_bits_data_0_14 = r_out[14];
  assign io_tensor_wr_0_bits_data_0_15 = r_out[15];

endmodule

// File: tb/tb_acc_row_packer.sv
// Directed bench for acc_row_packer: word-queue reference model checked every cycle, plus literal checks.
module tb_acc_row_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic [10:0] io_row_base;
  logic [11:0] io_row_cnt;
  logic [20:0] io_tag;
  logic        io_busy, io_done, io_tag_err, io_vme_rd_data_ready;
  logic        io_vme_rd_data_valid;
  logic [63:0] io_vme_rd_data_bits_data;
  logic [20:0] io_vme_rd_data_bits_tag;
  logic        io_tensor_wr_0_valid;
  logic [10:0] io_tensor_wr_0_bits_idx;
  logic [31:0] d_data [16];

  always #5 clock = ~clock;

  acc_row_packer dut (
    .clock(clock), .reset(reset),
    .io_start(io_start), .io_row_base(io_row_base), .io_row_cnt(io_row_cnt), .io_tag(io_tag),
    .io_busy(io_busy), .io_done(io_done), .io_tag_err(io_tag_err),
    .io_vme_rd_data_ready(io_vme_rd_data_ready), .io_vme_rd_data_valid(io_vme_rd_data_valid),
    .io_vme_rd_data_bits_data(io_vme_rd_data_bits_data), .io_vme_rd_data_bits_tag(io_vme_rd_data_bits_tag),
    .io_tensor_wr_0_valid(io_tensor_wr_0_valid), .io_tensor_wr_0_bits_idx(io_tensor_wr_0_bits_idx),
    .io_tensor_wr_0_bits_data_0_0(d_data[0]),   .io_tensor_wr_0_bits_data_0_1(d_data[1]),
    .io_tensor_wr_0_bits_data_0_2(d_data[2]),   .io_tensor_wr_0_bits_data_0_3(d_data[3]),
    .io_tensor_wr_0_bits_data_0_4(d_data[4]),   .io_tensor_wr_0_bits_data_0_5(d_data[5]),
    .io_tensor_wr_0_bits_data_0_6(d_data[6]),   .io_tensor_wr_0_bits_data_0_7(d_data[7]),
    .io_tensor_wr_0_bits_data_0_8(d_data[8]),   .io_tensor_wr_0_bits_data_0_9(d_data[9]),
    .io_tensor_wr_0_bits_data_0_10(d_data[10]), .io_tensor_wr_0_bits_data_0_11(d_data[11]),
    .io_tensor_wr_0_bits_data_0_12(d_data[12]), .io_tensor_wr_0_bits_data_0_13(d_data[13]),
    .io_tensor_wr_0_bits_data_0_14(d_data[14]), .io_tensor_wr_0_bits_data_0_15(d_data[15])
  );

`ifdef ACC_PACK_TAG_CHECK_EN
  localparam bit TAGCHK = 1'b1;
`else
  localparam bit TAGCHK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: a transfer is a list of 32-bit words; every 16 words make one row write.
  bit          m_busy = 1'b0;
  int          m_base = 0, m_cnt = 0, m_rows = 0;
  logic [20:0] m_tag = '0;
  logic [31:0] m_words [$];
  bit          e_done = 1'b0, e_err = 1'b0, e_valid = 1'b0;
  int          e_idx = 0;
  logic [31:0] e_data [16];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_valid = 1'b0; e_idx = 0;
      m_words.delete();
      for (int i = 0; i < 16; i++) e_data[i] = 32'd0;
    end else begin
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (!m_busy) begin
        if (io_start) begin
          if (TAGCHK) e_err = 1'b0;
          if (io_row_cnt == 12'd0) e_done = 1'b1;
          else begin
            m_busy = 1'b1; m_base = int'(io_row_base); m_cnt = int'(io_row_cnt);
            m_rows = 0; m_tag = io_tag; m_words.delete();
          end
        end
      end else if (io_vme_rd_data_valid) begin
        if (TAGCHK && io_vme_rd_data_bits_tag != m_tag) e_err = 1'b1;
        else begin
          m_words.push_back(io_vme_rd_data_bits_data[31:0]);
          m_words.push_back(io_vme_rd_data_bits_data[63:32]);
          if (m_words.size() == 16) begin
            e_valid = 1'b1;
            e_idx   = (m_base + m_rows) % 2048;
            for (int i = 0; i < 16; i++) e_data[i] = m_words[i];
            m_words.delete();
            m_rows++;
            if (m_rows == m_cnt) begin m_busy = 1'b0; e_done = 1'b1; end
          end
        end
      end
    end
  end

  // Write log and per-cycle comparison against the model.
  int          log_idx [$];
  logic [31:0] last_data [16];
  int          done_cyc = -1, done_cnt = 0, wr_cyc = -1, ready_cnt = 0;

  always @(negedge clock) begin
    total++;
    if ({io_busy, io_vme_rd_data_ready, io_done, io_tag_err, io_tensor_wr_0_valid} !==
        {m_busy, m_busy, e_done, e_err, e_valid}) begin
      bad++;
      $display("FAIL ctrl cyc=%0d got busy/rdy/done/err/wv=%b required %b", cyc,
               {io_busy, io_vme_rd_data_ready, io_done, io_tag_err, io_tensor_wr_0_valid},
               {m_busy, m_busy, e_done, e_err, e_valid});
    end
    total++;
    if (io_tensor_wr_0_bits_idx !== 11'(e_idx)) begin
      bad++;
      $display("FAIL idx cyc=%0d got %0d required %0d", cyc, io_tensor_wr_0_bits_idx, e_idx);
    end
    total++;
    begin
      int mm = -1;
      for (int i = 0; i < 16; i++) if (mm < 0 && d_data[i] !== e_data[i]) mm = i;
      if (mm >= 0) begin
        bad++;
        $display("FAIL data cyc=%0d elem %0d got %h required %h", cyc, mm, d_data[mm], e_data[mm]);
      end
    end
    if (io_tensor_wr_0_valid === 1'b1) begin
      log_idx.push_back(int'(io_tensor_wr_0_bits_idx));
      for (int i = 0; i < 16; i++) last_data[i] = d_data[i];
      wr_cyc = cyc;
      $display("write idx=%0d e0=%h e15=%h cyc=%0d", io_tensor_wr_0_bits_idx, d_data[0], d_data[15], cyc);
    end
    if (io_done === 1'b1) begin done_cyc = cyc; done_cnt++; end
    if (io_vme_rd_data_ready === 1'b1) ready_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else $display("check %s ok (%h)", name, act);
  endtask

  task automatic drive(input bit st, input logic [10:0] b, input logic [11:0] c, input logic [20:0] t,
                       input bit v, input logic [63:0] d, input logic [20:0] bt);
    @(negedge clock);
    io_start = st; io_row_base = b; io_row_cnt = c; io_tag = t;
    io_vme_rd_data_valid = v; io_vme_rd_data_bits_data = d; io_vme_rd_data_bits_tag = bt;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b0, 64'd0, 21'd0);
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'(2 * k + 1), 32'(2 * k)};
  endfunction

  task automatic clear_log();
    log_idx.delete(); done_cyc = -1; done_cnt = 0; wr_cyc = -1; ready_cnt = 0;
  endtask

  int s0;

  initial begin
    reset = 1'b1;
    io_start = 1'b0; io_row_base = '0; io_row_cnt = '0; io_tag = '0;
    io_vme_rd_data_valid = 1'b0; io_vme_rd_data_bits_data = '0; io_vme_rd_data_bits_tag = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(io_busy), 64'd0);
    chk("reset_valid_idx", {io_tensor_wr_0_valid, io_tensor_wr_0_bits_idx}, 64'd0);
    reset = 1'b0;
    idle(2);

    // Single row, base 5
    clear_log();
    drive(1'b1, 11'd5, 12'd1, 21'd0, 1'b0, 64'd0, 21'd0); s0 = cyc;
    for (int k = 0; k < 8; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    idle(3);
    chk("t1_nwrites", 64'(log_idx.size()), 64'd1);
    chk("t1_idx", 64'(log_idx.size() > 0 ? log_idx[0] : -1), 64'd5);
    chk("t1_e0", 64'(last_data[0]), 64'd0);
    chk("t1_e7", 64'(last_data[7]), 64'd7);
    chk("t1_e15", 64'(last_data[15]), 64'd15);
    chk("t1_done_cycle", 64'(done_cyc - s0), 64'd9);
    chk("t1_done_with_write", 64'(done_cyc), 64'(wr_cyc));

    // Wrap at 2047 with valid low every other cycle
    clear_log();
    drive(1'b1, 11'd2047, 12'd2, 21'd0, 1'b0, 64'd0, 21'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 21'd0);
      drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    end
    idle(4);
    chk("t2_nwrites", 64'(log_idx.size()), 64'd2);
    chk("t2_idx0", 64'(log_idx.size() > 0 ? log_idx[0] : -1), 64'd2047);
    chk("t2_idx1", 64'(log_idx.size() > 1 ? log_idx[1] : -1), 64'd0);
    chk("t2_e15", 64'(last_data[15]), 64'd31);
    chk("t2_ndone", 64'(done_cnt), 64'd1);
    chk("t2_done_with_write", 64'(done_cyc), 64'(wr_cyc));

    // Zero count
    clear_log();
    drive(1'b1, 11'd9, 12'd0, 21'd0, 1'b0, 64'd0, 21'd0); s0 = cyc;
    for (int k = 0; k < 3; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    idle(2);
    chk("t3_nwrites", 64'(log_idx.size()), 64'd0);
    chk("t3_ready_cnt", 64'(ready_cnt), 64'd0);
    chk("t3_done_cycle", 64'(done_cyc - s0), 64'd1);

    // Start while busy is ignored
    clear_log();
    drive(1'b1, 11'd10, 12'd3, 21'd0, 1'b0, 64'd0, 21'd0);
    for (int k = 0; k < 4; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    drive(1'b1, 11'd100, 12'd1, 21'd0, 1'b1, pat(4), 21'd0);
    for (int k = 5; k < 24; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    idle(3);
    chk("t4_nwrites", 64'(log_idx.size()), 64'd3);
    chk("t4_idx0", 64'(log_idx.size() > 0 ? log_idx[0] : -1), 64'd10);
    chk("t4_idx2", 64'(log_idx.size() > 2 ? log_idx[2] : -1), 64'd12);

    // Reset mid-row, then a clean single row
    clear_log();
    drive(1'b1, 11'd7, 12'd1, 21'd0, 1'b0, 64'd0, 21'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'd0);
    @(negedge clock);
    io_vme_rd_data_valid = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_ctrl", {io_busy, io_done, io_tag_err, io_vme_rd_data_ready, io_tensor_wr_0_valid}, 64'd0);
    chk("t5_rst_idx", 64'(io_tensor_wr_0_bits_idx), 64'd0);
    chk("t5_rst_e15", 64'(d_data[15]), 64'd0);
    #1 reset = 1'b0;
    drive(1'b1, 11'd3, 12'd1, 21'd0, 1'b0, 64'd0, 21'd0);
    for (int k = 0; k < 8; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k + 8), 21'd0);
    idle(3);
    chk("t5_nwrites", 64'(log_idx.size()), 64'd1);
    chk("t5_idx", 64'(log_idx.size() > 0 ? log_idx[0] : -1), 64'd3);
    chk("t5_e0", 64'(last_data[0]), 64'd16);

    // Tag mismatch beat injected as the 4th beat
    clear_log();
    drive(1'b1, 11'd0, 12'd1, 21'h15, 1'b0, 64'd0, 21'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'h15);
    drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 21'h16);
    for (int k = 3; k < 8; k++) drive(1'b0, 11'd0, 12'd0, 21'd0, 1'b1, pat(k), 21'h15);
    idle(3);
    chk("t6_nwrites", 64'(log_idx.size()), 64'd1);
    if (TAGCHK) begin
      chk("t6_e6", 64'(last_data[6]), 64'd6);
      chk("t6_e15", 64'(last_data[15]), 64'd15);
      chk("t6_err", 64'(io_tag_err), 64'd1);
    end else begin
      chk("t6_e6", 64'(last_data[6]), 64'hCAFEF00D);
      chk("t6_e7", 64'(last_data[7]), 64'hDEADBEEF);
      chk("t6_e15", 64'(last_data[15]), 64'd13);
      chk("t6_err", 64'(io_tag_err), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
